// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock divider bank: channel FSM encoding and default widths.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPending = 2'd2
  } chan_state_e;

  localparam int unsigned DefaultDivW = 16;

endpackage

// File: rtl/clock_divider_bank_if.sv
// Divisor configuration port: one request (channel, half-period) per valid/ready transfer.
interface clock_divider_bank_if
  import clk_gen_pkg::*;
#(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned DIV_W = DefaultDivW
);

  logic             I_cfg_valid;
  logic [CH_W-1:0]  I_cfg_chan;
  logic [DIV_W-1:0] I_cfg_div;
  logic             O_cfg_ready;

  modport master (
    output I_cfg_valid,
    output I_cfg_chan,
    output I_cfg_div,
    input  O_cfg_ready
  );

  modport slave (
    input  I_cfg_valid,
    input  I_cfg_chan,
    input  I_cfg_div,
    output O_cfg_ready
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divided-clock channel: 50% duty output, rise tick, shadowed divisor applied at rise points.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = DefaultDivW
) (
  input  logic             usb_clk,
  input  logic             reset_n,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             running_o,
  output logic             pending_o
);

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             last;
  logic             rise_pt;
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] start_div;
  logic [DIV_W-1:0] nxt_div;

  assign last    = (cnt_q == div_q - DIV_W'(1));
  assign rise_pt = !clk_q && last;

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    stop      = 1'b0;
    start_div = div_q;
    nxt_div   = (state_q == StPending) ? shadow_q : div_q;
    unique case (state_q)
      StIdle: begin
        if (wr_i && (wr_div_i != '0)) begin
          state_d   = StRun;
          start     = 1'b1;
          start_div = wr_div_i;
        end
      end
      StRun, StPending: begin
        if (sync_i) begin
          // A write in the sync cycle takes effect as part of the restart.
          start_div = wr_i ? wr_div_i : nxt_div;
          if (start_div == '0) begin
            stop    = 1'b1;
            state_d = StIdle;
          end else begin
            start   = 1'b1;
            state_d = StRun;
          end
        end else if (rise_pt) begin
          start_div = nxt_div;
          if (nxt_div == '0) begin
            stop    = 1'b1;
            state_d = StIdle;
          end else begin
            start   = 1'b1;
            state_d = wr_i ? StPending : StRun;
          end
        end else if (wr_i) begin
          state_d = StPending;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    shadow_d = wr_i ? wr_div_i : shadow_q;
    if (start) begin
      cnt_d  = '0;
      div_d  = start_div;
      clk_d  = 1'b1;
      tick_d = 1'b1;
    end else if (stop) begin
      cnt_d = '0;
      div_d = '0;
      clk_d = 1'b0;
    end else if (state_q != StIdle) begin
      if (last) begin
        cnt_d = '0;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      div_q    <= '0;
      shadow_q <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    clk_o     = clk_q;
    tick_o    = tick_q;
    running_o = (state_q != StIdle);
    pending_o = (state_q == StPending);
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independently programmable clock dividers with a shared phase-align sync.
module clock_divider_bank
  import clk_gen_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = DefaultDivW,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  usb_clk,
  input  logic                  reset_n,
  clock_divider_bank_if.slave   cfg,
  input  logic                  I_sync,
  output logic [NUM_CH-1:0]     O_clk,
  output logic [NUM_CH-1:0]     O_tick,
  output logic [NUM_CH-1:0]     O_running
);

  logic [CH_W-1:0]   chan_sel;
  logic              accept;
  logic              ready;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] pending;

  assign chan_sel        = cfg.I_cfg_chan;
  assign ready           = ~|pending;
  assign accept          = cfg.I_cfg_valid && ready;
  assign cfg.O_cfg_ready = ready;

  // Out-of-range channel indices match no channel, so the request is silently dropped.
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_chan
    assign wr[i] = accept && (int'(chan_sel) == i);

    clk_div_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .usb_clk   (usb_clk),
      .reset_n   (reset_n),
      .wr_i      (wr[i]),
      .wr_div_i  (cfg.I_cfg_div),
      .sync_i    (I_sync),
      .clk_o     (O_clk[i]),
      .tick_o    (O_tick[i]),
      .running_o (O_running[i]),
      .pending_o (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: a 4-channel instance plus a 1-channel, 8-bit instance.
module tb_clock_divider_bank;

  logic       usb_clk;
  logic       reset_n;
  logic       I_sync;
  logic [3:0] O_clk, O_tick, O_running;
  logic       sync1;
  logic [0:0] clk1, tick1, run1;

  int n_checks = 0;
  int n_fail   = 0;

  clock_divider_bank_if #(.CH_W(2), .DIV_W(16)) cfg ();
  clock_divider_bank_if #(.CH_W(1), .DIV_W(8))  cfg1 ();

  clock_divider_bank #(.NUM_CH(4), .DIV_W(16)) u_dut (
    .usb_clk   (usb_clk),
    .reset_n   (reset_n),
    .cfg       (cfg),
    .I_sync    (I_sync),
    .O_clk     (O_clk),
    .O_tick    (O_tick),
    .O_running (O_running)
  );

  clock_divider_bank #(.NUM_CH(1), .DIV_W(8)) u_dut1 (
    .usb_clk   (usb_clk),
    .reset_n   (reset_n),
    .cfg       (cfg1),
    .I_sync    (sync1),
    .O_clk     (clk1),
    .O_tick    (tick1),
    .O_running (run1)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int d);
    cfg.I_cfg_valid = 1'b1;
    cfg.I_cfg_chan  = 2'(ch);
    cfg.I_cfg_div   = 16'(d);
    step();
    cfg.I_cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (O_clk !== 4'b0 || O_tick !== 4'b0 || O_running !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got clk=%b tick=%b run=%b required all 0", O_clk, O_tick, O_running);
    end
    n_checks++;
    if (cfg.O_cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", cfg.O_cfg_ready);
    end
    step();
    reset_n = 1'b1;
    step();
    n_checks++;
    if (O_clk !== 4'b0 || O_running !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got clk=%b run=%b required 0", O_clk, O_running);
    end
  endtask

  // ch0 D=3: high k=1..3, low k=4..6, ticks at k=1,7,13.
  task automatic test_basic();
    logic ec, et;
    cfg_write(0, 3);
    for (int k = 1; k <= 13; k++) begin
      ec = ((k - 1) % 6) < 3;
      et = ((k - 1) % 6) == 0;
      n_checks++;
      if (O_clk[0] !== ec || O_tick[0] !== et) begin
        n_fail++;
        $display("FAIL basic_ch0 k=%0d: got clk=%b tick=%b required clk=%b tick=%b",
                 k, O_clk[0], O_tick[0], ec, et);
      end
      n_checks++;
      if (O_clk[3:1] !== 3'b0 || O_tick[3:1] !== 3'b0) begin
        n_fail++;
        $display("FAIL basic_others k=%0d: got clk=%b tick=%b required 0", k, O_clk[3:1], O_tick[3:1]);
      end
      step();
    end
  endtask

  // ch1 D=4 then D=2 written mid-high: old phases finish, rise at k=9 uses D=2.
  task automatic test_retarget();
    logic ec, et, er;
    cfg_write(1, 4);
    step();
    n_checks++;
    if (cfg.O_cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL retarget_ready_before: got %b required 1", cfg.O_cfg_ready);
    end
    cfg_write(1, 2);
    for (int k = 3; k <= 14; k++) begin
      ec = (k <= 4) ? 1'b1 : (k <= 8) ? 1'b0 : (((k - 9) % 4) < 2);
      et = (k == 9) || (k == 13);
      er = (k >= 9);
      n_checks++;
      if (O_clk[1] !== ec || O_tick[1] !== et || cfg.O_cfg_ready !== er) begin
        n_fail++;
        $display("FAIL retarget k=%0d: got clk=%b tick=%b ready=%b required clk=%b tick=%b ready=%b",
                 k, O_clk[1], O_tick[1], cfg.O_cfg_ready, ec, et, er);
      end
      step();
    end
  endtask

  // ch2 D=5 then stop: high k=1..5, low k=6..10, idle from k=11.
  task automatic test_stop();
    logic ec, er, ey;
    cfg_write(2, 5);
    step();
    cfg_write(2, 0);
    for (int k = 3; k <= 14; k++) begin
      ec = (k <= 5);
      er = (k <= 10);
      ey = (k >= 11);
      n_checks++;
      if (O_clk[2] !== ec || O_tick[2] !== 1'b0 || O_running[2] !== er || cfg.O_cfg_ready !== ey) begin
        n_fail++;
        $display("FAIL stop k=%0d: got clk=%b tick=%b run=%b ready=%b required clk=%b tick=0 run=%b ready=%b",
                 k, O_clk[2], O_tick[2], O_running[2], cfg.O_cfg_ready, ec, er, ey);
      end
      step();
    end
  endtask

  task automatic test_sync();
    logic e0, e1, t0, t1;
    int   guard;
    cfg_write(1, 5);
    guard = 0;
    while (cfg.O_cfg_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL sync_wait_ready: got ready=%b required 1 within 20 cycles", cfg.O_cfg_ready);
    end
    step();
    step();
    step();
    I_sync = 1'b1;
    step();
    I_sync = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      e0 = (k % 6) < 3;
      e1 = (k % 10) < 5;
      t0 = (k % 6) == 0;
      t1 = (k % 10) == 0;
      n_checks++;
      if (O_clk[1:0] !== {e1, e0} || O_tick[1:0] !== {t1, t0} || O_clk[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL sync_align k=%0d: got clk=%b tick=%b required clk=%b%b%b tick=%b%b",
                 k, O_clk[2:0], O_tick[1:0], 1'b0, e1, e0, t1, t0);
      end
      step();
    end
    // Pending divisor is applied by the sync itself.
    cfg_write(1, 3);
    n_checks++;
    if (cfg.O_cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_pending_ready: got %b required 0", cfg.O_cfg_ready);
    end
    I_sync = 1'b1;
    step();
    I_sync = 1'b0;
    n_checks++;
    if (cfg.O_cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_applied_ready: got %b required 1", cfg.O_cfg_ready);
    end
    for (int k = 0; k <= 6; k++) begin
      e0 = (k % 6) < 3;
      n_checks++;
      if (O_clk[1:0] !== {e0, e0}) begin
        n_fail++;
        $display("FAIL sync_pending k=%0d: got clk=%b required %b%b", k, O_clk[1:0], e0, e0);
      end
      step();
    end
    // Idle channel written in the sync cycle starts aligned.
    I_sync          = 1'b1;
    cfg.I_cfg_valid = 1'b1;
    cfg.I_cfg_chan  = 2'd2;
    cfg.I_cfg_div   = 16'd2;
    step();
    I_sync          = 1'b0;
    cfg.I_cfg_valid = 1'b0;
    n_checks++;
    if (O_clk[2:0] !== 3'b111 || O_tick[2:0] !== 3'b111) begin
      n_fail++;
      $display("FAIL sync_accept: got clk=%b tick=%b required 111/111", O_clk[2:0], O_tick[2:0]);
    end
    step();
    step();
    n_checks++;
    if (O_clk[2:0] !== 3'b011) begin
      n_fail++;
      $display("FAIL sync_accept_k2: got clk=%b required 011", O_clk[2:0]);
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(3, 4);
    n_checks++;
    if (O_clk[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_high: got %b required 1", O_clk[3]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (O_clk !== 4'b0 || O_tick !== 4'b0 || O_running !== 4'b0 || cfg.O_cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_async: got clk=%b tick=%b run=%b ready=%b required 0/0/0/1",
               O_clk, O_tick, O_running, cfg.O_cfg_ready);
    end
    #3;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (O_clk !== 4'b0 || O_running !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got clk=%b run=%b required 0", O_clk, O_running);
    end
  endtask

  task automatic test_single();
    logic e;
    int   guard, hi, lo;
    // Channel index 1 is out of range for a 1-channel bank.
    cfg1.I_cfg_valid = 1'b1;
    cfg1.I_cfg_chan  = 1'b1;
    cfg1.I_cfg_div   = 8'd7;
    step();
    cfg1.I_cfg_valid = 1'b0;
    n_checks++;
    if (cfg1.O_cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_ready: got %b required 1", cfg1.O_cfg_ready);
    end
    step();
    step();
    n_checks++;
    if (clk1 !== 1'b0 || run1 !== 1'b0 || tick1 !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_outputs: got clk=%b run=%b tick=%b required 0", clk1, run1, tick1);
    end
    cfg1.I_cfg_valid = 1'b1;
    cfg1.I_cfg_chan  = 1'b0;
    cfg1.I_cfg_div   = 8'd1;
    step();
    cfg1.I_cfg_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      e = (k % 2) == 1;
      n_checks++;
      if (clk1[0] !== e || tick1[0] !== e) begin
        n_fail++;
        $display("FAIL div1 k=%0d: got clk=%b tick=%b required %b/%b", k, clk1[0], tick1[0], e, e);
      end
      step();
    end
    cfg1.I_cfg_valid = 1'b1;
    cfg1.I_cfg_div   = 8'd255;
    step();
    cfg1.I_cfg_valid = 1'b0;
    step();
    guard = 0;
    while (tick1[0] !== 1'b1 && guard < 600) begin
      step();
      guard++;
    end
    hi = 0;
    while (clk1[0] === 1'b1 && hi < 600) begin
      hi++;
      step();
    end
    lo = 0;
    while (clk1[0] === 1'b0 && lo < 600) begin
      lo++;
      step();
    end
    n_checks++;
    if (guard >= 600 || hi != 255 || lo != 255) begin
      n_fail++;
      $display("FAIL divmax: got high=%0d low=%0d wait=%0d required high=255 low=255", hi, lo, guard);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    I_sync           = 1'b0;
    sync1            = 1'b0;
    cfg.I_cfg_valid  = 1'b0;
    cfg.I_cfg_chan   = '0;
    cfg.I_cfg_div    = '0;
    cfg1.I_cfg_valid = 1'b0;
    cfg1.I_cfg_chan  = '0;
    cfg1.I_cfg_div   = '0;
    test_reset();
    test_basic();
    test_retarget();
    test_stop();
    test_sync();
    test_reset_mid();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
